// File: rtl/user_port_rx_buffer.sv
// Receive-side buffer between a leaf interface and user logic: a small
// first-word-fall-through FIFO with frame delimiting on the output side.
module user_port_rx_buffer #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_LOG2   = 3,
    parameter int FRAME_LEN    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    vld_in,
    output logic                    ack_out,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic                    dout_last,
    output logic [DEPTH_LOG2:0]     level,
    output logic [15:0]             frame_cnt
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]         LAST_IDX   = 16'(FRAME_LEN - 1);

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           wordIdx_q, wordIdx_d;
    logic [15:0]           frameCnt_q, frameCnt_d;

    logic doWrite;
    logic doRead;

    // Handshakes come only from registered occupancy, so ack_out never
    // depends combinationally on vld_in; a full FIFO refuses even if a read
    // frees a slot in the same cycle.
    assign ack_out   = (level_q != FULL_LEVEL);
    assign dout_vld  = (level_q != '0);
    assign dout      = mem[rdPtr_q];
    assign dout_last = dout_vld && (wordIdx_q == LAST_IDX);
    assign level     = level_q;
    assign frame_cnt = frameCnt_q;

    assign doWrite = vld_in && ack_out;
    assign doRead  = dout_vld && dout_rdy;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        wordIdx_d  = wordIdx_q;
        frameCnt_d = frameCnt_q;

        if (doWrite) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end

        if (doRead) begin
            rdPtr_d = rdPtr_q + 1'b1;
            if (wordIdx_q == LAST_IDX) begin
                wordIdx_d  = '0;
                frameCnt_d = frameCnt_q + 16'd1;
            end else begin
                wordIdx_d = wordIdx_q + 16'd1;
            end
        end

        case ({doWrite, doRead})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            wordIdx_q  <= '0;
            frameCnt_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            wordIdx_q  <= wordIdx_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr_q] <= din;
        end
    end

endmodule

// File: tb/tb_user_port_rx_buffer.sv
// Directed self-checking bench for user_port_rx_buffer: flow, backpressure,
// pointer wrap, framing, mid-frame reset and empty-read behaviour.
module tb_user_port_rx_buffer;

    localparam int PAYLOAD_BITS = 32;
    localparam int DEPTH_LOG2   = 3;
    localparam int FRAME_LEN    = 16;

    logic                    clk;
    logic                    reset;
    logic [PAYLOAD_BITS-1:0] din;
    logic                    vld_in;
    logic                    ack_out;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    dout_vld;
    logic                    dout_rdy;
    logic                    dout_last;
    logic [DEPTH_LOG2:0]     level;
    logic [15:0]             frame_cnt;

    int compareCount;
    int mismatchCount;

    user_port_rx_buffer #(
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .FRAME_LEN   (FRAME_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .vld_in   (vld_in),
        .ack_out  (ack_out),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .dout_last(dout_last),
        .level    (level),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [PAYLOAD_BITS-1:0] data,
                                 input logic rdy);
        vld_in   = vld;
        din      = data;
        dout_rdy = rdy;
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic clockTick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
        clockTick();
        reset = 1'b1;
    endtask

    initial begin
        int acc;
        int rdIdx;
        int wrIdx;
        int cyc;

        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);

        // Reset state, observed while reset is still held low.
        #2;
        reset = 1'b0;
        #2;
        checkOutput("rstVld", dout_vld, 0);
        checkOutput("rstLast", dout_last, 0);
        checkOutput("rstAck", ack_out, 1);
        checkOutput("rstLevel", level, 0);
        checkOutput("rstFrames", frame_cnt, 0);
        clockTick();
        reset = 1'b1;
        clockTick();
        checkOutput("postRstAck", ack_out, 1);
        checkOutput("postRstLevel", level, 0);

        // Basic flow: each word appears one cycle after its write.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b1);
            clockTick();
            checkOutput("flowData", dout, 64'hA0 + 64'(i));
            checkOutput("flowVld", dout_vld, 1);
            checkOutput("flowLevel", level, 1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        clockTick();
        checkOutput("flowDrained", level, 0);

        // Full backpressure.
        doReset();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'hB0 + 32'(i), 1'b0);
            if (ack_out) acc++;
            clockTick();
        end
        checkOutput("fullAccepted", acc, 8);
        checkOutput("fullLevel", level, 8);
        checkOutput("fullAck", ack_out, 0);
        checkOutput("fullHead", dout, 64'hB0);
        applyStimulus(1'b1, 32'hC9, 1'b1);
        clockTick();
        checkOutput("fullNoWrite", level, 7);
        checkOutput("ackRises", ack_out, 1);
        applyStimulus(1'b1, 32'hC9, 1'b0);
        clockTick();
        checkOutput("ninthAccepted", level, 8);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            checkOutput("fullOrder", dout, 64'hB0 + 64'(i));
            clockTick();
        end
        checkOutput("ninthWord", dout, 64'hC9);
        clockTick();
        checkOutput("fullDrained", level, 0);

        // Simultaneous read/write at level 4 across pointer wrap.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hD0 + 32'(i), 1'b0);
            clockTick();
        end
        checkOutput("rwLevelStart", level, 4);
        rdIdx = 0;
        for (int i = 4; i < 20; i++) begin
            applyStimulus(1'b1, 32'hD0 + 32'(i), 1'b1);
            checkOutput("rwOrder", dout, 64'hD0 + 64'(rdIdx));
            rdIdx++;
            clockTick();
            checkOutput("rwLevel", level, 4);
        end
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rwDrain", dout, 64'hD0 + 64'(rdIdx));
            rdIdx++;
            clockTick();
        end
        checkOutput("rwEmpty", level, 0);

        // Framing: 48 words with random backpressure on the user side.
        doReset();
        wrIdx = 0;
        rdIdx = 0;
        cyc   = 0;
        while (rdIdx < 48 && cyc < 2000) begin
            applyStimulus(wrIdx < 48, 32'h100 + 32'(wrIdx), 1'($urandom_range(0, 1)));
            if (vld_in && ack_out) wrIdx++;
            if (dout_vld) begin
                checkOutput("frameData", dout, 64'h100 + 64'(rdIdx));
                checkOutput("frameLast", dout_last, 64'((rdIdx % FRAME_LEN) == FRAME_LEN - 1));
                if (dout_rdy) rdIdx++;
            end
            clockTick();
            cyc++;
        end
        checkOutput("frameReads", rdIdx, 48);
        checkOutput("frameCount", frame_cnt, 3);

        // Reset mid-frame: 5 words read, 3 still buffered.
        applyStimulus(1'b0, '0, 1'b1);
        clockTick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'hE0 + 32'(i), 1'b0);
            clockTick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) clockTick();
        checkOutput("midLevel", level, 3);
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstLevel", level, 0);
        checkOutput("midRstVld", dout_vld, 0);
        checkOutput("midRstFrames", frame_cnt, 0);
        reset = 1'b1;
        clockTick();
        checkOutput("midAck", ack_out, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'hF0 + 32'(i), 1'b1);
            clockTick();
            checkOutput("midData", dout, 64'hF0 + 64'(i));
            checkOutput("midLast", dout_last, 64'(i == 15));
        end
        applyStimulus(1'b0, '0, 1'b1);
        clockTick();
        checkOutput("midFrames", frame_cnt, 1);

        // Empty read: dout_rdy with nothing buffered changes nothing.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            clockTick();
            checkOutput("emptyVld", dout_vld, 0);
            checkOutput("emptyLast", dout_last, 0);
            checkOutput("emptyLevel", level, 0);
        end
        checkOutput("emptyFrames", frame_cnt, 1);
        applyStimulus(1'b1, 32'h5A, 1'b0);
        clockTick();
        checkOutput("emptyNextData", dout, 64'h5A);
        checkOutput("emptyNextLast", dout_last, 0);
        checkOutput("emptyNextLevel", level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/user_port_rx_buffer.md
USER_PORT_RX_BUFFER -- requirements
Module: user_port_rx_buffer

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 32, meaning the payload word width.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of the FIFO depth (DEPTH = 2^DEPTH_LOG2 = 8).
REQ-003 The block SHALL have parameter FRAME_LEN, default 16, meaning payload words per frame (legal range 1..65535).
REQ-004 The block SHALL have port clk  input  1  clock for all state.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port din  input  PAYLOAD_BITS  payload word from leaf interface (interface-to-user data).
REQ-007 The block SHALL have port vld_in  input  1  din valid (interface-to-user valid).
REQ-008 The block SHALL have port ack_out  output  1  accept indication to the leaf interface (user-to-interface ack).
REQ-009 The block SHALL have port dout  output  PAYLOAD_BITS  word presented to user logic.
REQ-010 The block SHALL have port dout_vld  output  1  dout holds a valid word.
REQ-011 The block SHALL have port dout_rdy  input  1  user logic accepts dout.
REQ-012 The block SHALL have port dout_last  output  1  dout is the final word of a frame.
REQ-013 The block SHALL have port level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH.
REQ-014 The block SHALL have port frame_cnt  output  16  number of completed frames delivered.

Function
REQ-015 The block SHALL drive ack_out = (level != DEPTH), derived only from registered state, with no combinational path from vld_in.
REQ-016 The block SHALL perform a write when vld_in && ack_out at a rising clk edge: it stores din at wr_ptr and advances wr_ptr modulo DEPTH.
REQ-017 The block SHALL present first-word-fall-through output: dout = mem[rd_ptr] and dout_vld = (level != 0).
REQ-018 The block SHALL perform a read when dout_vld && dout_rdy at a rising clk edge, advancing rd_ptr modulo DEPTH.
REQ-019 Write-to-output latency SHALL be 1 cycle: a word written into an empty FIFO appears on dout with dout_vld=1 in the next cycle.
REQ-020 On a cycle with both a read and a write, level SHALL stay unchanged; write only: level+1; read only: level-1.
REQ-021 When full, ack_out SHALL be 0 and no write SHALL occur, even if a read happens in the same cycle; ack_out SHALL rise in the cycle after the read.
REQ-022 When empty, dout_rdy SHALL be ignored; no read, pointer, or counter change SHALL occur.
REQ-023 A word-index counter (16 bits) SHALL increment on each read and wrap to 0 on the read where it equals FRAME_LEN-1.
REQ-024 The block SHALL drive dout_last = dout_vld && (word index == FRAME_LEN-1); with FRAME_LEN=1, every valid word SHALL be last.
REQ-025 frame_cnt SHALL increment by 1 on each read with dout_last=1 and wrap from 65535 to 0.
REQ-026 Pointers SHALL be DEPTH_LOG2 bits and wrap naturally; level SHALL never exceed DEPTH or go below 0.
REQ-027 Data order SHALL be strictly FIFO; no word SHALL be dropped or duplicated.
REQ-028 The block SHALL hold dout and dout_last stable while dout_vld=1 and dout_rdy=0.

Reset
REQ-029 While reset=0, asynchronously and regardless of clk, the block SHALL clear wr_ptr, rd_ptr, level, the word index, and frame_cnt to 0.
REQ-030 During and immediately after reset, outputs SHALL be dout_vld=0, dout_last=0, ack_out=1, level=0, and frame_cnt=0; dout is don't-care, and memory contents are not reset.
REQ-031 Reset asserted mid-frame or mid-transfer SHALL discard all buffered words and restart frame counting at word 0; the first cycle after reset deassertion SHALL accept writes.

Verification
REQ-032 Basic flow: reset; write 0xA0..0xA3 on consecutive cycles with dout_rdy=1 -> dout yields A0..A3, each 1 cycle after its write; level never exceeds 1.
REQ-033 Full backpressure: dout_rdy=0; drive vld_in=1 for 10 cycles -> exactly 8 words accepted, ack_out=0 with level=8; raise dout_rdy for 1 cycle -> ack_out=1 next cycle, and the 9th word is accepted.
REQ-034 Simultaneous read/write at level 4 -> level stays 4 and order is preserved across pointer wrap (write 20 words, check sequence).
REQ-035 Framing: FRAME_LEN=16; stream 48 words with random dout_rdy -> dout_last on words 15, 31, 47 only; frame_cnt=3.
REQ-036 Reset mid-frame: after 5 reads and 3 buffered words, pulse reset=0 -> level=0, dout_vld=0, frame_cnt=0; the next 16 words produce dout_last on the 16th.
REQ-037 Empty read: level=0, dout_rdy=1 for 5 cycles -> no pointer change and no dout_last; frame_cnt is unchanged.
